// File: rtl/cpu_run_pkg.sv
// Shared types and default constants for the core run controller.
package cpu_run_pkg;

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2,
      TMO  = 2'd3
   } run_state_e;

   localparam logic [31:0] DEF_HALT_PC      = 32'h0000_3ffc;
   localparam int          DEF_RESET_CYCLES = 4;
   localparam int          DEF_MAX_CYCLES   = 100000;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr has priority over en.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (en && (q_q != {W{1'b1}})) begin
         q_d = q_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run sequencer for the MIPS core: stretched core reset, cycle/retire counting,
// and self-termination on halt PC, tight self-loop or cycle budget.
//
// state | meaning
// HOLD  | core held in reset for RESET_CYCLES after reset drops
// RUN   | core executing, counters live
// HALT  | halt PC or self-loop seen; frozen until reset
// TMO   | cycle budget exhausted; frozen until reset
module cpu_run_ctrl
   import cpu_run_pkg::*;
#(
   parameter int              PC_W         = 32,
   parameter int              CNT_W        = 32,
   parameter int              RESET_CYCLES = DEF_RESET_CYCLES,
   parameter int              MAX_CYCLES   = DEF_MAX_CYCLES,
   parameter logic [PC_W-1:0] HALT_PC      = PC_W'(DEF_HALT_PC),
   parameter bit              HALT_PC_EN   = 1'b1,
   parameter int              LOOP_LIMIT   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PC_W-1:0]  pc_in,
   input  logic             pc_valid,
   output logic             cpu_reset,
   output logic             running,
   output logic             halted,
   output logic             timed_out,
   output logic             done,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instr_count
);

   localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam int REP_W  = $clog2(LOOP_LIMIT + 1) + 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
   localparam logic [REP_W-1:0]  REP_LAST  = REP_W'((LOOP_LIMIT >= 2) ? LOOP_LIMIT - 2 : 0);
   localparam logic [CNT_W-1:0]  CYC_LAST  = CNT_W'(MAX_CYCLES - 1);

   run_state_e        state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [PC_W-1:0]   last_pc_q, last_pc_d;
   logic [REP_W-1:0]  rep_cnt;
   logic              cyc_en, ins_en, rep_en, rep_clr;
   logic              pc_same, loop_hit, halt_hit;

   assign pc_same = (pc_in == last_pc_q);

   // rep_cnt counts repeats after the first retirement, so the Nth identical one sees N-2.
   always_comb begin
      loop_hit = 1'b0;
      if (LOOP_LIMIT == 1) begin
         loop_hit = 1'b1;
      end else if (LOOP_LIMIT >= 2) begin
         loop_hit = pc_same && (rep_cnt == REP_LAST);
      end
   end

   assign halt_hit = pc_valid && ((HALT_PC_EN && (pc_in == HALT_PC)) || loop_hit);

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      last_pc_d  = last_pc_q;
      cyc_en     = 1'b0;
      ins_en     = 1'b0;
      rep_en     = 1'b0;
      rep_clr    = 1'b0;
      case (state_q)
         HOLD: begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            if (hold_cnt_q == HOLD_LAST) begin
               hold_cnt_d = '0;
               state_d    = RUN;
            end
         end
         RUN: begin
            cyc_en = 1'b1;
            if (pc_valid) begin
               ins_en = 1'b1;
               if (pc_same) begin
                  rep_en = 1'b1;
               end else begin
                  rep_clr   = 1'b1;
                  last_pc_d = pc_in;
               end
            end
            // Halt takes priority over a coincident timeout.
            if (halt_hit) begin
               state_d = HALT;
            end else if (cycle_count == CYC_LAST) begin
               state_d = TMO;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= HOLD;
         hold_cnt_q <= '0;
         last_pc_q  <= '0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         last_pc_q  <= last_pc_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .en    (cyc_en),
      .q     (cycle_count)
   );

   sat_counter #(.W(CNT_W)) u_instr_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .en    (ins_en),
      .q     (instr_count)
   );

   sat_counter #(.W(REP_W)) u_rep_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (rep_clr),
      .en    (rep_en),
      .q     (rep_cnt)
   );

   assign cpu_reset = (state_q == HOLD);
   assign running   = (state_q == RUN);
   assign halted    = (state_q == HALT);
   assign timed_out = (state_q == TMO);
   assign done      = (state_q == HALT) || (state_q == TMO);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: three parameterisations share one stimulus; run outcomes
// are queued when a run starts and matched when the selected instance reports done.
module tb_cpu_run_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        pc_valid = 1'b0;
   logic [31:0] pc_in = '0;

   always #5 clk = ~clk;

   logic        a_cpu_reset, a_running, a_halted, a_timed_out, a_done;
   logic [31:0] a_cycle, a_instr;
   logic        b_cpu_reset, b_running, b_halted, b_timed_out, b_done;
   logic [31:0] b_cycle, b_instr;
   logic        c_cpu_reset, c_running, c_halted, c_timed_out, c_done;
   logic [3:0]  c_cycle, c_instr;

   cpu_run_ctrl #(.RESET_CYCLES(4), .MAX_CYCLES(50), .LOOP_LIMIT(8)) dut_a (
      .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid),
      .cpu_reset(a_cpu_reset), .running(a_running), .halted(a_halted),
      .timed_out(a_timed_out), .done(a_done), .cycle_count(a_cycle), .instr_count(a_instr)
   );

   cpu_run_ctrl #(.RESET_CYCLES(4), .MAX_CYCLES(50), .LOOP_LIMIT(0)) dut_b (
      .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid),
      .cpu_reset(b_cpu_reset), .running(b_running), .halted(b_halted),
      .timed_out(b_timed_out), .done(b_done), .cycle_count(b_cycle), .instr_count(b_instr)
   );

   cpu_run_ctrl #(.CNT_W(4), .RESET_CYCLES(4), .MAX_CYCLES(15), .HALT_PC_EN(1'b0)) dut_c (
      .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid),
      .cpu_reset(c_cpu_reset), .running(c_running), .halted(c_halted),
      .timed_out(c_timed_out), .done(c_done), .cycle_count(c_cycle), .instr_count(c_instr)
   );

   int sel = 0;
   logic        m_cpu_reset, m_running, m_halted, m_timed_out, m_done;
   logic [31:0] m_cycle, m_instr;

   always_comb begin
      m_cpu_reset = a_cpu_reset; m_running = a_running; m_halted = a_halted;
      m_timed_out = a_timed_out; m_done = a_done; m_cycle = a_cycle; m_instr = a_instr;
      case (sel)
         1: begin
            m_cpu_reset = b_cpu_reset; m_running = b_running; m_halted = b_halted;
            m_timed_out = b_timed_out; m_done = b_done; m_cycle = b_cycle; m_instr = b_instr;
         end
         2: begin
            m_cpu_reset = c_cpu_reset; m_running = c_running; m_halted = c_halted;
            m_timed_out = c_timed_out; m_done = c_done;
            m_cycle = {28'd0, c_cycle}; m_instr = {28'd0, c_instr};
         end
         default: ;
      endcase
   end

   typedef struct {
      logic        halted;
      logic        timed_out;
      int unsigned instr;
      int unsigned cycles;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic prev_done = 1'b0;

   // Outcome monitor: pops one expected result on each rising done of the selected instance.
   always @(negedge clk) begin
      if (m_done === 1'b1 && prev_done !== 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_done sel=%0d got done=1 exp no pending run", sel);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (m_halted !== e.halted || m_timed_out !== e.timed_out ||
                m_instr !== e.instr || m_cycle !== e.cycles) begin
               errors++;
               $display("FAIL sb_outcome sel=%0d got h=%0b t=%0b i=%0d c=%0d exp h=%0b t=%0b i=%0d c=%0d",
                        sel, m_halted, m_timed_out, m_instr, m_cycle,
                        e.halted, e.timed_out, e.instr, e.cycles);
            end
         end
      end
      prev_done = m_done;
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input int s, output int hold_seen);
      int g;
      pc_valid = 1'b0;
      reset = 1'b1;
      step;
      sel = s;
      step;
      reset = 1'b0;
      hold_seen = 0;
      g = 0;
      while (m_running !== 1'b1 && g < 30) begin
         if (m_cpu_reset === 1'b1) hold_seen++;
         g++;
         step;
      end
   endtask

   task automatic wait_done(output bit ok);
      int g;
      g = 0;
      while (m_done !== 1'b1 && g < 200) begin
         step;
         g++;
      end
      ok = (m_done === 1'b1);
      step;
   endtask

   task automatic test_reset;
      int hold_seen;
      int g;
      pc_valid = 1'b0;
      reset = 1'b1;
      step;
      sel = 0;
      step;
      checks++;
      if (m_cpu_reset !== 1'b1 || m_running !== 1'b0 || m_halted !== 1'b0 ||
          m_timed_out !== 1'b0 || m_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got rst=%0b run=%0b h=%0b t=%0b d=%0b exp 1 0 0 0 0",
                  m_cpu_reset, m_running, m_halted, m_timed_out, m_done);
      end
      checks++;
      if (m_cycle !== 32'd0 || m_instr !== 32'd0) begin
         errors++;
         $display("FAIL reset_counts got c=%0d i=%0d exp 0 0", m_cycle, m_instr);
      end
      reset = 1'b0;
      hold_seen = 0;
      g = 0;
      while (m_running !== 1'b1 && g < 30) begin
         if (m_cpu_reset === 1'b1) hold_seen++;
         g++;
         step;
      end
      checks++;
      if (hold_seen !== 4) begin
         errors++;
         $display("FAIL reset_hold_len got %0d exp 4", hold_seen);
      end
      checks++;
      if (m_running !== 1'b1 || m_cpu_reset !== 1'b0 || m_cycle !== 32'd0) begin
         errors++;
         $display("FAIL reset_release got run=%0b rst=%0b c=%0d exp 1 0 0",
                  m_running, m_cpu_reset, m_cycle);
      end
   endtask

   task automatic test_halt_pc;
      int h;
      logic [31:0] pcs [4];
      pcs = '{32'h3000, 32'h3004, 32'h3008, 32'h3ffc};
      start_run(0, h);
      sb.push_back('{halted: 1'b1, timed_out: 1'b0, instr: 4, cycles: 4});
      for (int i = 0; i < 4; i++) begin
         pc_in = pcs[i];
         pc_valid = 1'b1;
         step;
         if (i == 2) begin
            checks++;
            if (m_done !== 1'b0) begin
               errors++;
               $display("FAIL halt_pc_early got done=%0b exp 0", m_done);
            end
         end
      end
      checks++;
      if (m_halted !== 1'b1 || m_done !== 1'b1 || m_running !== 1'b0) begin
         errors++;
         $display("FAIL halt_pc_edge got h=%0b d=%0b run=%0b exp 1 1 0", m_halted, m_done, m_running);
      end
      for (int i = 0; i < 20; i++) begin
         pc_in = (i % 2 == 0) ? 32'h3ffc : $urandom;
         pc_valid = 1'b1;
         step;
      end
      pc_valid = 1'b0;
      checks++;
      if (m_instr !== 32'd4 || m_cycle !== 32'd4 || m_halted !== 1'b1 || m_cpu_reset !== 1'b0) begin
         errors++;
         $display("FAIL halt_pc_frozen got i=%0d c=%0d h=%0b rst=%0b exp 4 4 1 0",
                  m_instr, m_cycle, m_halted, m_cpu_reset);
      end
   endtask

   task automatic test_self_loop;
      int h;
      bit ok;
      start_run(0, h);
      sb.push_back('{halted: 1'b1, timed_out: 1'b0, instr: 8, cycles: 8});
      pc_in = 32'h3010;
      pc_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step;
         if (i == 6) begin
            checks++;
            if (m_done !== 1'b0) begin
               errors++;
               $display("FAIL loop_early got done=%0b exp 0 after 7 retirements", m_done);
            end
         end
      end
      checks++;
      if (m_halted !== 1'b1) begin
         errors++;
         $display("FAIL loop_halt got h=%0b exp 1", m_halted);
      end
      pc_valid = 1'b0;
      step;

      start_run(1, h);
      sb.push_back('{halted: 1'b0, timed_out: 1'b1, instr: 50, cycles: 50});
      pc_in = 32'h3010;
      pc_valid = 1'b1;
      wait_done(ok);
      pc_valid = 1'b0;
      checks++;
      if (!ok || m_halted !== 1'b0 || m_timed_out !== 1'b1) begin
         errors++;
         $display("FAIL loop_disabled got ok=%0b h=%0b t=%0b exp 1 0 1", ok, m_halted, m_timed_out);
      end
   endtask

   task automatic test_timeout;
      int h;
      int g;
      bit ok;
      start_run(0, h);
      sb.push_back('{halted: 1'b0, timed_out: 1'b1, instr: 0, cycles: 50});
      pc_valid = 1'b0;
      wait_done(ok);
      checks++;
      if (!ok || m_timed_out !== 1'b1 || m_cycle !== 32'd50) begin
         errors++;
         $display("FAIL timeout_plain got ok=%0b t=%0b c=%0d exp 1 1 50", ok, m_timed_out, m_cycle);
      end

      start_run(0, h);
      sb.push_back('{halted: 1'b1, timed_out: 1'b0, instr: 1, cycles: 50});
      g = 0;
      while (m_cycle !== 32'd49 && g < 100) begin
         step;
         g++;
      end
      pc_in = 32'h3ffc;
      pc_valid = 1'b1;
      step;
      pc_valid = 1'b0;
      checks++;
      if (m_halted !== 1'b1 || m_timed_out !== 1'b0 || m_cycle !== 32'd50) begin
         errors++;
         $display("FAIL timeout_vs_halt got h=%0b t=%0b c=%0d exp 1 0 50", m_halted, m_timed_out, m_cycle);
      end
      step;
   endtask

   task automatic test_mid_run_reset;
      int h;
      int g;
      start_run(0, h);
      g = 0;
      pc_valid = 1'b1;
      while (m_cycle !== 32'd17 && g < 100) begin
         pc_in = 32'h100 + 32'(g * 4);
         step;
         g++;
      end
      pc_valid = 1'b0;
      checks++;
      if (m_instr !== 32'd17 || m_running !== 1'b1) begin
         errors++;
         $display("FAIL midrun_pre got i=%0d run=%0b exp 17 1", m_instr, m_running);
      end
      reset = 1'b1;
      step;
      reset = 1'b0;
      checks++;
      if (m_cpu_reset !== 1'b1 || m_running !== 1'b0 || m_cycle !== 32'd0 || m_instr !== 32'd0) begin
         errors++;
         $display("FAIL midrun_reset got rst=%0b run=%0b c=%0d i=%0d exp 1 0 0 0",
                  m_cpu_reset, m_running, m_cycle, m_instr);
      end
      h = 0;
      g = 0;
      while (m_running !== 1'b1 && g < 30) begin
         if (m_cpu_reset === 1'b1) h++;
         g++;
         step;
      end
      checks++;
      if (h !== 4) begin
         errors++;
         $display("FAIL midrun_hold_len got %0d exp 4", h);
      end
   endtask

   task automatic test_saturation;
      int h;
      int g;
      start_run(2, h);
      sb.push_back('{halted: 1'b0, timed_out: 1'b1, instr: 15, cycles: 15});
      g = 0;
      pc_valid = 1'b1;
      while (m_done !== 1'b1 && g < 100) begin
         pc_in = 32'h200 + 32'(g * 4);
         step;
         g++;
      end
      for (int i = 0; i < 5; i++) begin
         pc_in = 32'h800 + 32'(i * 4);
         step;
      end
      pc_valid = 1'b0;
      checks++;
      if (m_instr !== 32'd15 || m_cycle !== 32'd15 || m_timed_out !== 1'b1) begin
         errors++;
         $display("FAIL saturation got i=%0d c=%0d t=%0b exp 15 15 1", m_instr, m_cycle, m_timed_out);
      end
   endtask

   initial begin
      test_reset;
      test_halt_pc;
      test_self_loop;
      test_timeout;
      test_mid_run_reset;
      test_saturation;
      step;
      step;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_pending got %0d unmatched runs exp 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller for the pipelined MIPS core in simulation and on-board bring-up. Stretches the external synchronous reset into a fixed-length core reset, then counts cycles and retired instructions and ends the run on a halt PC, a tight self-loop, or a cycle timeout. It replaces a free-running clock/reset stimulus with a parametrised, self-terminating run sequencer that drives `mips.reset` and observes the core's retire stream.

## Interface
Parameters:
- PC_W, 32, PC width.
- CNT_W, 32, width of the cycle and instruction counters.
- RESET_CYCLES, 4, cycles `cpu_reset` is held after `reset` drops; must be ≥1.
- MAX_CYCLES, 100000, run-cycle budget before timeout; must be ≥1 and < 2^CNT_W.
- HALT_PC, 32'h0000_3ffc, PC that terminates the run.
- HALT_PC_EN, 1, enables HALT_PC detection.
- LOOP_LIMIT, 8, consecutive retirements of the same PC that count as a halt; 0 disables.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high.
- pc_in  in  PC_W  PC of the instruction retiring this cycle.
- pc_valid  in  1  pc_in is valid; one retirement this cycle.
- cpu_reset  out  1  reset to the core.
- running  out  1  core is executing; state RUN.
- halted  out  1  run ended by halt PC or self-loop.
- timed_out  out  1  run ended by cycle budget.
- done  out  1  halted | timed_out.
- cycle_count  out  CNT_W  RUN cycles elapsed.
- instr_count  out  CNT_W  retirements observed in RUN.

## Operation
- States: HOLD, RUN, HALT, TMO. HALT and TMO are terminal until `reset`.
- Reset values: state = HOLD, `hold_cnt` = 0, `cpu_reset` = 1, `running`/`halted`/`timed_out`/`done` = 0, both counts = 0, `last_pc` = 0, `rep_cnt` = 0.
- HOLD:
  - `cpu_reset` = 1 and `hold_cnt` increments each cycle.
  - When `hold_cnt` = RESET_CYCLES-1, move to RUN on the next edge.
- RUN:
  - `cpu_reset` = 0 and `cycle_count` increments every cycle.
  - If `pc_valid`: increment `instr_count`.
  - If also `pc_in` = `last_pc`: increment `rep_cnt`. Otherwise clear `rep_cnt` and load `last_pc` from `pc_in`.
- Halt condition, evaluated on `pc_valid`: either
  - HALT_PC_EN and `pc_in` = HALT_PC, or
  - LOOP_LIMIT>0, `pc_in` = `last_pc`, and `rep_cnt` = LOOP_LIMIT-2, i.e. the LOOP_LIMIT-th identical retirement. For LOOP_LIMIT = 1, every retirement halts.
- Timeout condition: `cycle_count` = MAX_CYCLES-1 in RUN.
- Halt and timeout in the same cycle: halt wins, go to HALT.
- HALT/TMO: `cpu_reset` stays 0, counters and `last_pc` freeze, and `pc_valid` is ignored.
- Counters saturate at all-ones; they never wrap.
- `pc_valid` in HOLD is ignored.

## Timing
- All outputs are registered; no combinational input-to-output path.
- `cpu_reset` is high for every cycle `reset` is high plus exactly RESET_CYCLES cycles after. `running` rises on the same edge `cpu_reset` falls.
- The halting retirement is counted: after a halt, `instr_count` includes it. `halted`/`done` assert on the edge after it.
- Timeout: `timed_out` asserts on the edge where `cycle_count` becomes MAX_CYCLES. Final `cycle_count` = MAX_CYCLES.
- Reset mid-run (any state): on the next edge the block returns to HOLD with all reset values; `cpu_reset` = 1 in that cycle.

## Structure
- Package `cpu_run_pkg`:
  - state enum (HOLD, RUN, HALT, TMO);
  - default constants for HALT_PC, RESET_CYCLES, MAX_CYCLES.
- Sub-module `sat_counter` (parameter W; ports clk, reset, clr, en, q), instantiated for `cycle_count`, `instr_count` and `rep_cnt`.
- FSM, `last_pc` register and compare logic stay in `cpu_run_ctrl`.

## Test plan
- Reset sequence: `reset` high for 2 cycles, RESET_CYCLES = 4 -> `cpu_reset` high for 6 cycles, `running` = 1 on edge 7, `cycle_count` = 0 at that point.
- Halt PC: retire 0x3000, 0x3004, 0x3008, then 0x3ffc -> `halted` = 1 and `done` = 1 one edge later, `instr_count` = 4, counts frozen for 20 further cycles.
- Self-loop: LOOP_LIMIT = 8, retire 0x3010 every cycle -> `halted` after the 8th retirement, `instr_count` = 8; with LOOP_LIMIT = 0 the same stimulus ends in timeout instead.
- Timeout: MAX_CYCLES = 50, no halt PC -> `timed_out` = 1 and `cycle_count` = 50. With HALT_PC retired in cycle 50 (`cycle_count` = 49) -> `halted` = 1 and `timed_out` = 0.
- Reset mid-run: assert `reset` at `cycle_count` = 17 -> next edge gives `cpu_reset` = 1, `running` = 0, counts = 0, and a full RESET_CYCLES hold follows.
- Saturation: CNT_W = 4, MAX_CYCLES = 15, `pc_valid` every cycle at distinct PCs -> `instr_count` stops at 15 with no wrap, and `timed_out` = 1.
